// File: rtl/flex_stp_deser.sv
// Serial-to-parallel deserializer with a valid/ready holding register and sticky overrun.
// Optional even-parity frame bit is enabled by defining PARITY_CHECK_EN.
module flex_stp_deser #(
  parameter int NUM_BITS  = 8,
  parameter int SHIFT_MSB = 1,
  parameter int RESET_VAL = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          shift_enable,
  input  logic                          serial_in,
  input  logic                          clear,
  input  logic                          word_ready,
  output logic                          word_valid,
  output logic [NUM_BITS-1:0]           parallel_out,
  output logic [$clog2(NUM_BITS+2)-1:0] bit_count,
  output logic                          overrun,
  output logic                          parity_err
);

  localparam int CW = $clog2(NUM_BITS + 2);
`ifdef PARITY_CHECK_EN
  localparam int FRAME = NUM_BITS + 1;
`else
  localparam int FRAME = NUM_BITS;
`endif
  localparam logic [CW-1:0]       LAST = CW'(FRAME - 1);
  localparam logic [NUM_BITS-1:0] FILL = {NUM_BITS{RESET_VAL[0]}};

  // Handshake: parallel_out/parity_err are held stable while word_valid=1;
  // a word is consumed on any rising edge where word_valid && word_ready.
  logic [NUM_BITS-1:0] sr;
  logic [NUM_BITS-1:0] sr_next;
  logic [NUM_BITS-1:0] word;
  logic                last_bit;
  logic                complete;
  logic                data_bit;
  logic                word_perr;

  always_comb begin
    sr_next = sr;
    if (SHIFT_MSB != 0) sr_next = {sr[NUM_BITS-2:0], serial_in};
    else                sr_next = {serial_in, sr[NUM_BITS-1:1]};
  end

  assign last_bit = (bit_count == LAST);
  assign complete = shift_enable & ~clear & last_bit;

`ifdef PARITY_CHECK_EN
  // The parity bit closes the frame but never enters the shift register.
  assign data_bit  = ~last_bit;
  assign word      = sr;
  assign word_perr = ^{sr, serial_in};
`else
  assign data_bit  = 1'b1;
  assign word      = sr_next;
  assign word_perr = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      sr           <= FILL;
      parallel_out <= FILL;
      bit_count    <= '0;
      word_valid   <= 1'b0;
      overrun      <= 1'b0;
      parity_err   <= 1'b0;
    end else begin
      if (clear) begin
        sr        <= FILL;
        bit_count <= '0;
        overrun   <= 1'b0;
      end else if (shift_enable) begin
        if (data_bit) sr <= sr_next;
        if (last_bit) bit_count <= '0;
        else          bit_count <= bit_count + CW'(1);
      end

      if (complete) begin
        if (!word_valid || word_ready) begin
          parallel_out <= word;
          parity_err   <= word_perr;
          word_valid   <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (word_valid && word_ready) begin
        word_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_flex_stp_deser.sv
// Bench for flex_stp_deser: MSB-first and LSB-first instances share stimulus; a negedge
// monitor pops expected words from per-instance queues whenever a new word is presented.
module tb_flex_stp_deser;

  logic       clk = 1'b0;
  logic       rst, shift_enable, serial_in, clear, word_ready;
  logic       vm, vl, om, ol, pem, pel;
  logic [7:0] pom, pol;
  logic [3:0] bcm, bcl;

  int n_checks = 0;
  int n_errors = 0;

  logic [8:0] exp_q_m[$];
  logic [8:0] exp_q_l[$];

  logic pv_m = 1'b0, pa_m = 1'b0, pv_l = 1'b0, pa_l = 1'b0;

  always #5 clk = ~clk;

  flex_stp_deser #(.NUM_BITS(8), .SHIFT_MSB(1), .RESET_VAL(1)) dut_m (
    .clk(clk), .rst(rst), .shift_enable(shift_enable), .serial_in(serial_in),
    .clear(clear), .word_ready(word_ready), .word_valid(vm), .parallel_out(pom),
    .bit_count(bcm), .overrun(om), .parity_err(pem)
  );

  flex_stp_deser #(.NUM_BITS(8), .SHIFT_MSB(0), .RESET_VAL(1)) dut_l (
    .clk(clk), .rst(rst), .shift_enable(shift_enable), .serial_in(serial_in),
    .clear(clear), .word_ready(word_ready), .word_valid(vl), .parallel_out(pol),
    .bit_count(bcl), .overrun(ol), .parity_err(pel)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] rev8(input logic [7:0] w);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = w[7-i];
    return r;
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic shift_bit(input logic b);
    shift_enable = 1'b1;
    serial_in    = b;
    @(posedge clk); #1;
    shift_enable = 1'b0;
  endtask

  // Sends w MSB first; the LSB-first instance therefore holds the bit-reversed word.
  task automatic send_frame(input logic [7:0] w, input bit push, input bit ready_last,
                            input bit bad_par);
`ifdef PARITY_CHECK_EN
    logic par;
    par = (^w) ^ bad_par;
`endif
    for (int i = 7; i >= 0; i--) begin
`ifndef PARITY_CHECK_EN
      if (i == 0 && ready_last) word_ready = 1'b1;
`endif
      shift_bit(w[i]);
    end
`ifdef PARITY_CHECK_EN
    if (ready_last) word_ready = 1'b1;
    shift_bit(par);
`endif
    if (push) begin
      exp_q_m.push_back({bad_par, w});
      exp_q_l.push_back({bad_par, rev8(w)});
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      pv_m = 1'b0; pa_m = 1'b0; pv_l = 1'b0; pa_l = 1'b0;
    end else begin
      if (vm && (!pv_m || pa_m)) begin
        if (exp_q_m.size() == 0) check("msb_spurious_word", 1, 0);
        else check("msb_word", {23'd0, pem, pom}, {23'd0, exp_q_m.pop_front()});
      end
      if (vl && (!pv_l || pa_l)) begin
        if (exp_q_l.size() == 0) check("lsb_spurious_word", 1, 0);
        else check("lsb_word", {23'd0, pel, pol}, {23'd0, exp_q_l.pop_front()});
      end
      pv_m = vm; pa_m = vm && word_ready;
      pv_l = vl; pa_l = vl && word_ready;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    logic [7:0] w;
    rst = 1'b1; shift_enable = 1'b0; serial_in = 1'b0; clear = 1'b0; word_ready = 1'b0;
    idle(2);
    rst = 1'b0;
    check("rst_valid", vm, 0);
    check("rst_pout", pom, 8'hFF);
    check("rst_bitcount", bcm, 0);
    check("rst_overrun", om, 0);
    check("rst_parity", pem, 0);

    // Basic word with consumer always ready.
    word_ready = 1'b1;
    send_frame(8'hA5, 1, 0, 0);
    check("t1_valid", vm, 1);
    check("t1_pout_msb", pom, 8'hA5);
    check("t1_pout_lsb", pol, 8'hA5);
    idle(1);
    check("t1_valid_drop", vm, 0);

    send_frame(8'hF0, 1, 0, 0);
    check("t2_pout_lsb", pol, 8'h0F);
    check("t2_pout_msb", pom, 8'hF0);
    idle(2);

    // Back-to-back random stream.
    for (int k = 0; k < 6; k++) begin
      w = 8'($urandom_range(0, 255));
      send_frame(w, 1, 0, 0);
    end
    idle(2);

    // Overrun: second word dropped while first is held.
    word_ready = 1'b0;
    send_frame(8'h3C, 1, 0, 0);
    send_frame(8'hC3, 0, 0, 0);
    check("t3_pout_held", pom, 8'h3C);
    check("t3_overrun_msb", om, 1);
    check("t3_overrun_lsb", ol, 1);
    clear = 1'b1;
    idle(1);
    clear = 1'b0;
    check("t3_overrun_cleared", om, 0);
    check("t3_valid_kept", vm, 1);
    word_ready = 1'b1;
    idle(1);
    check("t3_consumed", vm, 0);

    // Clear mid-frame with a concurrent shift_enable.
    for (int k = 0; k < 5; k++) shift_bit(1'($urandom_range(0, 1)));
    check("t4_bitcount5", bcm, 5);
    clear = 1'b1; shift_enable = 1'b1; serial_in = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0; shift_enable = 1'b0;
    check("t4_bitcount_cleared", bcm, 0);
    check("t4_no_valid", vm, 0);
    w = 8'($urandom_range(0, 255));
    send_frame(w, 1, 0, 0);
    check("t4_one_word", vm, 1);
    check("t4_pout", pom, w);
    idle(3);
    check("t4_idle_no_valid", vm, 0);

    // Consume and completion on the same edge.
    word_ready = 1'b0;
    send_frame(8'h5A, 1, 0, 0);
    w = 8'($urandom_range(0, 255));
    send_frame(w, 1, 1, 0);
    check("t7_valid_stays", vm, 1);
    check("t7_new_word", pom, w);
    check("t7_no_overrun", om, 0);
    idle(1);
    check("t7_consumed", vm, 0);

    // Reset mid-frame with a held word.
    word_ready = 1'b0;
    w = 8'($urandom_range(0, 254));
    send_frame(w, 1, 0, 0);
    for (int k = 0; k < 4; k++) shift_bit(1'b0);
    check("t5_bitcount4", bcm, 4);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    check("t5_valid", vm, 0);
    check("t5_bitcount", bcm, 0);
    check("t5_pout", pom, 8'hFF);
    check("t5_pout_lsb", pol, 8'hFF);
    word_ready = 1'b1;
    idle(2);

`ifdef PARITY_CHECK_EN
    send_frame(8'hA5, 1, 0, 0);
    check("t6_parity_ok", pem, 0);
    idle(1);
    send_frame(8'hA5, 1, 0, 1);
    check("t6_parity_err", pem, 1);
    idle(2);
`endif

    check("exp_q_m_empty", exp_q_m.size(), 0);
    check("exp_q_l_empty", exp_q_l.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
